// File: rtl/pmu_auth_pkg.sv
// Shared state encoding and word geometry for the PMU SHA-256 authentication loader.
package pmu_auth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_INIT,
      ST_WAIT,
      ST_CHECK,
      ST_LOCK
   } state_t;

   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 16;
   localparam int BLK_WORDS = 8;

endpackage

// File: rtl/pmu_auth_sipo.sv
// Serial-in/parallel-out word assembler: MSB first, flags the cycle in which the
// 32nd bit is present so the completed word can be captured at that edge.
module pmu_auth_sipo
   import pmu_auth_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic              sin,
   output logic [WORD_W-1:0] word,
   output logic              word_done
);

   // Only the 31 pending bits are stored; the completed word is formed with the live bit.
   logic [WORD_W-2:0] shreg;
   logic [4:0]        bit_cnt;

   assign word      = {shreg, sin};
   assign word_done = en && (bit_cnt == 5'd31);

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (clr) begin
         bit_cnt <= '0;
      end else if (en) begin
         shreg   <= word[WORD_W-2:0];
         bit_cnt <= bit_cnt + 5'd1;
      end
   end

endmodule

// File: rtl/pmu_auth_loader.sv
// Session controller: loads 8 block words and 8 digest words into the sha256
// register file, kicks the core, samples the compare result and tracks lockout.
module pmu_auth_loader
   import pmu_auth_pkg::*;
#(
   parameter int WAIT_CYCLES = 80,
   parameter int MAX_FAIL    = 3,
   parameter int FAILW       = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              sin,
   input  logic              sin_valid,
   output logic              sha_cs,
   output logic              sha_we,
   output logic              sha_wc,
   output logic [2:0]        sha_address,
   output logic [WORD_W-1:0] sha_write_data,
   input  logic              sha_digest_valid,
   output logic              busy,
   output logic              auth_done,
   output logic              auth_ok,
   output logic              locked,
   output logic [FAILW-1:0]  fail_count
);

   localparam int               WAITW      = $clog2(WAIT_CYCLES + 1);
   localparam logic [WAITW-1:0] WAIT_LOAD  = WAITW'(WAIT_CYCLES - 1);
   localparam logic [FAILW-1:0] FAIL_LIMIT = FAILW'(MAX_FAIL);
   localparam logic [3:0]       LAST_WORD  = 4'(NUM_WORDS - 1);
   localparam logic [3:0]       BLK_LIMIT  = 4'(BLK_WORDS);

   state_t            state, state_d;
   logic [3:0]        word_cnt;
   logic [WAITW-1:0]  wait_cnt;
   logic              shift_en;
   logic              sipo_clr;
   logic              word_done;
   logic [WORD_W-1:0] word;
   logic [FAILW-1:0]  fail_next;
   logic              lock_hit;
   logic              last_we;

   pmu_auth_sipo u_sipo (
      .clk       (clk),
      .reset     (reset),
      .clr       (sipo_clr),
      .en        (shift_en),
      .sin       (sin),
      .word      (word),
      .word_done (word_done)
   );

   assign fail_next = fail_count + FAILW'(1);
   assign lock_hit  = (fail_next == FAIL_LIMIT);
   assign last_we   = sha_we && (word_cnt == LAST_WORD);

   assign busy      = (state != ST_IDLE) && (state != ST_LOCK);
   assign sha_cs    = (state == ST_INIT);
   assign auth_done = (state == ST_CHECK);

   always_comb begin
      state_d  = state;
      shift_en = 1'b0;
      sipo_clr = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               sipo_clr = 1'b1;
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // Bits arriving alongside the final write strobe belong to no word.
            if (last_we) state_d = ST_INIT;
            else         shift_en = sin_valid;
         end
         ST_INIT:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (wait_cnt == '0) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (!sha_digest_valid && lock_hit) state_d = ST_LOCK;
            else                               state_d = ST_IDLE;
         end
         ST_LOCK:  state_d = ST_LOCK;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         sha_we         <= 1'b0;
         sha_wc         <= 1'b0;
         sha_address    <= '0;
         sha_write_data <= '0;
         word_cnt       <= '0;
         wait_cnt       <= '0;
         auth_ok        <= 1'b0;
         locked         <= 1'b0;
         fail_count     <= '0;
      end else begin
         state  <= state_d;
         sha_we <= word_done;

         if (state == ST_IDLE && start) begin
            auth_ok  <= 1'b0;
            word_cnt <= '0;
         end

         // Address, select and data stay put until the next word completes.
         if (word_done) begin
            sha_write_data <= word;
            sha_address    <= word_cnt[2:0];
            sha_wc         <= (word_cnt < BLK_LIMIT);
         end

         if (sha_we) word_cnt <= word_cnt + 4'd1;

         if (state == ST_INIT)                        wait_cnt <= WAIT_LOAD;
         else if (state == ST_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - WAITW'(1);

         if (state == ST_CHECK) begin
            auth_ok <= sha_digest_valid;
            if (sha_digest_valid) begin
               fail_count <= '0;
            end else begin
               fail_count <= fail_next;
               if (lock_hit) begin
                  locked         <= 1'b1;
                  sha_wc         <= 1'b0;
                  sha_address    <= '0;
                  sha_write_data <= '0;
               end
            end
         end
      end
   end

endmodule
